// File: rtl/leitor_tabuleiro.sv
// leitor_tabuleiro: scans the reed-switch matrix row by row, debounces full-board snapshots
// and reports newly occupied squares. Define LEITOR_REMOCAO_EN to add the removeu output.
module leitor_tabuleiro #(
  parameter int N_ROWS        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilitar,
  input  logic [N_ROWS-1:0] colunas_sense,
  output logic [N_ROWS-1:0] linhas_drive,
  output logic [3:0]        jogadaFileira,
  output logic [3:0]        jogadaColuna,
  output logic              temJogada,
  output logic              multipla,
`ifdef LEITOR_REMOCAO_EN
  output logic              removeu,
`endif
  output logic [3:0]        db_estado
);

  localparam int NB = N_ROWS * N_ROWS;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int CW = $clog2(NB + 1);

  localparam logic [3:0]    LAST_ROW    = 4'(N_ROWS - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE);

  typedef enum logic [1:0] {
    INICIAL = 2'd0,
    DRIVE   = 2'd1,
    COMPARA = 2'd2,
    AVALIA  = 2'd3
  } estado_t;

  estado_t       estadoReg, estadoNext;
  logic [3:0]    rowReg, rowNext;
  logic [SW-1:0] settleReg, settleNext;
  logic [DW-1:0] cntReg, cntInc;
  logic          primedReg;
  logic [NB-1:0] scanFlat;
  logic [NB-1:0] lastScanReg;
  logic [NB-1:0] refReg;
  logic [3:0]    fileiraReg, colunaReg;

  logic [N_ROWS-1:0] scanLinha [N_ROWS];

  logic          ultimoSettle, ultimaLinha, captura;
  logic          iguais, estavel, mudou, avalia, ativo;
  logic [NB-1:0] novos;
  logic [CW-1:0] nNovos;
  logic [7:0]    posNovos;
  logic          emiteJogada, emiteMultipla;

  function automatic logic [CW-1:0] contaUns(input logic [NB-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Only meaningful when exactly one bit is set: ORing the indices then yields that square.
  function automatic logic [7:0] posicao(input logic [NB-1:0] v);
    logic [7:0] p;
    p = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_ROWS; c++) begin
        if (v[r*N_ROWS+c]) begin
          p = p | {4'(r), 4'(c)};
        end
      end
    end
    return p;
  endfunction

  assign ultimoSettle = (settleReg == LAST_SETTLE);
  assign ultimaLinha  = (rowReg == LAST_ROW);
  assign ativo        = (estadoReg == DRIVE) || (estadoReg == COMPARA);
  assign captura      = (estadoReg == DRIVE) && habilitar && ultimoSettle;
  assign iguais       = (scanFlat == lastScanReg);
  assign cntInc       = iguais ? ((cntReg == DB_MAX) ? cntReg : cntReg + 1'b1) : DW'(1);
  assign estavel      = (cntInc == DB_MAX);
  assign mudou        = (scanFlat != refReg);
  assign avalia       = (estadoReg == AVALIA);

  assign novos         = scanFlat & ~refReg;
  assign nNovos        = contaUns(novos);
  assign posNovos      = posicao(novos);
  assign emiteJogada   = avalia && primedReg && (nNovos == CW'(1));
  assign emiteMultipla = avalia && primedReg && (nNovos > CW'(1));

`ifdef LEITOR_REMOCAO_EN
  logic [NB-1:0] removidos;
  logic [CW-1:0] nRemovidos;
  logic [7:0]    posRemovidos;
  logic          emiteRemocao;

  assign removidos    = refReg & ~scanFlat;
  assign nRemovidos   = contaUns(removidos);
  assign posRemovidos = posicao(removidos);
  assign emiteRemocao = avalia && primedReg && (nNovos == '0) && (nRemovidos == CW'(1));
`endif

  // Each row owns its slice of the snapshot, written on the last settle cycle of its drive.
  for (genvar gi = 0; gi < N_ROWS; gi++) begin : gLinha
    always_ff @(posedge clock) begin
      if (reset) begin
        scanLinha[gi] <= '0;
      end else if (captura && (rowReg == 4'(gi))) begin
        scanLinha[gi] <= colunas_sense;
      end
    end
    assign scanFlat[gi*N_ROWS +: N_ROWS] = scanLinha[gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoReg <= INICIAL;
      rowReg    <= '0;
      settleReg <= '0;
    end else begin
      estadoReg <= estadoNext;
      rowReg    <= rowNext;
      settleReg <= settleNext;
    end
  end

  always_comb begin
    estadoNext = estadoReg;
    rowNext    = rowReg;
    settleNext = settleReg;
    unique case (estadoReg)
      INICIAL: begin
        if (habilitar) begin
          estadoNext = DRIVE;
          rowNext    = '0;
          settleNext = '0;
        end
      end
      DRIVE: begin
        if (!habilitar) begin
          estadoNext = INICIAL;
        end else if (!ultimoSettle) begin
          settleNext = settleReg + 1'b1;
        end else begin
          settleNext = '0;
          if (ultimaLinha) begin
            estadoNext = COMPARA;
          end else begin
            rowNext = rowReg + 1'b1;
          end
        end
      end
      COMPARA: begin
        if (!habilitar) begin
          estadoNext = INICIAL;
        end else begin
          estadoNext = (estavel && mudou) ? AVALIA : DRIVE;
          rowNext    = '0;
          settleNext = '0;
        end
      end
      AVALIA: begin
        estadoNext = DRIVE;
        rowNext    = '0;
        settleNext = '0;
      end
      default: estadoNext = INICIAL;
    endcase
  end

  // Dropping the enable throws away the debounce progress but keeps the reference board.
  always_ff @(posedge clock) begin
    if (reset) begin
      cntReg      <= '0;
      primedReg   <= 1'b0;
      lastScanReg <= '0;
      refReg      <= '0;
      fileiraReg  <= '0;
      colunaReg   <= '0;
    end else begin
      if (ativo && !habilitar) begin
        cntReg <= '0;
      end else if (estadoReg == COMPARA) begin
        cntReg <= cntInc;
        if (!iguais) begin
          lastScanReg <= scanFlat;
        end
      end
      if (avalia) begin
        refReg    <= scanFlat;
        primedReg <= 1'b1;
      end
      if (emiteJogada) begin
        fileiraReg <= posNovos[7:4];
        colunaReg  <= posNovos[3:0];
      end
`ifdef LEITOR_REMOCAO_EN
      if (emiteRemocao) begin
        fileiraReg <= posRemovidos[7:4];
        colunaReg  <= posRemovidos[3:0];
      end
`endif
    end
  end

  always_comb begin
    linhas_drive  = '0;
    temJogada     = 1'b0;
    multipla      = 1'b0;
    jogadaFileira = fileiraReg;
    jogadaColuna  = colunaReg;
    db_estado     = {2'b00, estadoReg};
    if (estadoReg == DRIVE) begin
      linhas_drive = N_ROWS'(1) << rowReg;
    end
    if (emiteJogada) begin
      temJogada     = 1'b1;
      jogadaFileira = posNovos[7:4];
      jogadaColuna  = posNovos[3:0];
    end
    if (emiteMultipla) begin
      multipla = 1'b1;
    end
`ifdef LEITOR_REMOCAO_EN
    removeu = 1'b0;
    if (emiteRemocao) begin
      removeu       = 1'b1;
      jogadaFileira = posRemovidos[7:4];
      jogadaColuna  = posRemovidos[3:0];
    end
`endif
  end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Scoreboard bench for leitor_tabuleiro: a board-level model predicts move events per completed
// scan; a monitor pops and compares every pulse the reader emits.
module tb_leitor_tabuleiro;

  localparam int N   = 8;
  localparam int SET = 4;
  localparam int DB  = 3;

  logic         clock;
  logic         reset;
  logic         habilitar;
  logic [N-1:0] sense;
  logic [N-1:0] linhas_drive;
  logic [3:0]   jogadaFileira, jogadaColuna, db_estado;
  logic         temJogada, multipla, removeuW;

  logic [63:0]  board;

  typedef struct packed {
    logic [1:0] kind;   // 0 = jogada, 1 = multipla, 2 = removeu
    logic [3:0] f;
    logic [3:0] c;
  } evento_t;

  evento_t expQ[$];
  int      checks   = 0;
  int      failures = 0;

  // reference model state
  logic [63:0] refM, runB;
  int          runLen;
  bit          primedM;
  logic [3:0]  modelF, modelC;

  leitor_tabuleiro #(.N_ROWS(N), .SETTLE_CYCLES(SET), .DEBOUNCE(DB)) dut (
    .clock         (clock),
    .reset         (reset),
    .habilitar     (habilitar),
    .colunas_sense (sense),
    .linhas_drive  (linhas_drive),
    .jogadaFileira (jogadaFileira),
    .jogadaColuna  (jogadaColuna),
    .temJogada     (temJogada),
    .multipla      (multipla),
`ifdef LEITOR_REMOCAO_EN
    .removeu       (removeuW),
`endif
    .db_estado     (db_estado)
  );

`ifndef LEITOR_REMOCAO_EN
  assign removeuW = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The physical board: the driven row sees its own pieces on the column lines.
  always_comb begin
    sense = '0;
    for (int r = 0; r < N; r++) begin
      if (linhas_drive[r]) sense = board[r*N +: N];
    end
  end

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nome, got, exp, $time);
    end
  endtask

  function automatic evento_t mkEv(input logic [1:0] k, input logic [3:0] f, input logic [3:0] c);
    evento_t e;
    e.kind = k;
    e.f    = f;
    e.c    = c;
    return e;
  endfunction

  // One complete scan of board b has been taken by the reader.
  task automatic modelScan(input logic [63:0] b);
    logic [63:0] novos, remov;
    if (b == runB) runLen++;
    else begin
      runB   = b;
      runLen = 1;
    end
    if (runLen >= DB && b != refM) begin
      novos = b & ~refM;
      remov = refM & ~b;
      if (!primedM) begin
        primedM = 1'b1;
      end else if ($countones(novos) == 1) begin
        for (int i = 0; i < 64; i++) if (novos[i]) begin
          modelF = 4'(i / N);
          modelC = 4'(i % N);
        end
        expQ.push_back(mkEv(2'd0, modelF, modelC));
      end else if ($countones(novos) > 1) begin
        expQ.push_back(mkEv(2'd1, modelF, modelC));
      end
`ifdef LEITOR_REMOCAO_EN
      else if ($countones(remov) == 1) begin
        for (int i = 0; i < 64; i++) if (remov[i]) begin
          modelF = 4'(i / N);
          modelC = 4'(i % N);
        end
        expQ.push_back(mkEv(2'd2, modelF, modelC));
      end
`endif
      refM = b;
    end
  endtask

  task automatic waitCompara();
    int t = 0;
    @(negedge clock);
    while (db_estado != 4'd2 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("espera_compara", 64'(db_estado), 64'd2);
  endtask

  task automatic step(input logic [63:0] b, input int scans);
    board = b;
    $display("step board=%016h scans=%0d", b, scans);
    for (int k = 0; k < scans; k++) begin
      waitCompara();
      modelScan(board);
    end
  endtask

  task automatic stepDisable();
    int t = 0;
    @(negedge clock);
    while (linhas_drive != 8'h20 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("espera_linha5", 64'(linhas_drive), 64'h20);
    @(negedge clock);
    habilitar = 1'b0;
    @(negedge clock);
    chk("desab_drive", 64'(linhas_drive), 64'h0);
    chk("desab_estado", 64'(db_estado), 64'h0);
    repeat (9) @(negedge clock);
    habilitar = 1'b1;
    runLen = 0;
    @(negedge clock);
    chk("reinicio_linha0", 64'(linhas_drive), 64'h01);
    $display("step disable/enable board=%016h", board);
    waitCompara();
    modelScan(board);
  endtask

  evento_t    monE;
  logic [1:0] gotKind;
  logic [3:0] heldF = 4'd0, heldC = 4'd0;

  always @(negedge clock) begin
    if (!reset) begin
      if (temJogada || multipla || removeuW) begin
        chk("pulso_exclusivo", 64'(temJogada & multipla), 64'd0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL evento_inesperado tem=%0b mult=%0b rem=%0b exp=nenhum t=%0t",
                   temJogada, multipla, removeuW, $time);
        end else begin
          monE    = expQ.pop_front();
          gotKind = temJogada ? 2'd0 : (multipla ? 2'd1 : 2'd2);
          $display("evento kind=%0d fileira=%0d coluna=%0d (exp kind=%0d %0d/%0d)",
                   gotKind, jogadaFileira, jogadaColuna, monE.kind, monE.f, monE.c);
          chk("tipo_evento", 64'(gotKind), 64'(monE.kind));
          chk("fileira_evento", 64'(jogadaFileira), 64'(monE.f));
          chk("coluna_evento", 64'(jogadaColuna), 64'(monE.c));
          heldF = monE.f;
          heldC = monE.c;
        end
      end else begin
        chk("fileira_mantida", 64'(jogadaFileira), 64'(heldF));
        chk("coluna_mantida", 64'(jogadaColuna), 64'(heldC));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_tempo t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b;
    logic [7:0]  e;
    int          bit_i;
    refM    = '0;
    runB    = '0;
    runLen  = 0;
    primedM = 1'b0;
    modelF  = '0;
    modelC  = '0;
    board     = '0;
    reset     = 1'b1;
    habilitar = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_drive", 64'(linhas_drive), 64'h0);
    chk("reset_fileira", 64'(jogadaFileira), 64'h0);
    chk("reset_coluna", 64'(jogadaColuna), 64'h0);
    chk("reset_tem", 64'(temJogada), 64'h0);
    chk("reset_multipla", 64'(multipla), 64'h0);
    chk("reset_estado", 64'(db_estado), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("inicial_sem_hab", 64'(db_estado), 64'h0);
    habilitar = 1'b1;
    for (int k = 0; k <= N * SET; k++) begin
      @(negedge clock);
      e = (k < N * SET) ? 8'(1 << (k / SET)) : 8'h00;
      chk("varredura_drive", 64'(linhas_drive), 64'(e));
    end
    modelScan(board);

    b = 64'hFFFF_0000_0000_FFFF;
    step(b, 4);                                  // initial load, no pulse
    b = b | (64'd1 << 35);
    step(b, 4);                                  // row 4 col 3
    step(b | (64'd1 << 21), 1);                  // one-scan glitch at row 2 col 5
    step(b, 4);
    b = b | (64'd1 << 24) | (64'd1 << 47);
    step(b, 4);                                  // two at once -> multipla
    stepDisable();
    step(b, 3);
    b = b & ~(64'd1 << 35);
    step(b, 4);                                  // lift row 4 col 3

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        stepDisable();
      end else begin
        b = board;
        for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
          bit_i    = int'($urandom_range(0, 63));
          b[bit_i] = ~b[bit_i];
        end
        step(b, int'($urandom_range(1, 4)));
      end
    end
    step(board, 4);
    repeat (4) @(negedge clock);
    chk("fila_vazia", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
